// File: rtl/ts_pkg.sv
// Shared types and constants for the touch-panel poll controller.
package ts_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdStat,
    StRdXl,
    StRdXh,
    StRdYl,
    StRdYh,
    StWrClr,
    StDone
  } ts_state_e;

  localparam int unsigned TOUCH_BIT       = 7;
  localparam int unsigned CNT_MSB         = 3;
  localparam logic [15:0] DEF_STAT_ADDR   = 16'h814E;
  localparam int unsigned DEF_POLL_CYCLES = 1000000;

  // Register address targeted by the command issued on entry to a state.
  function automatic logic [15:0] reg_addr(logic [15:0] stat_addr, ts_state_e st);
    case (st)
      StRdXl:  return stat_addr + 16'd2;
      StRdXh:  return stat_addr + 16'd3;
      StRdYl:  return stat_addr + 16'd4;
      StRdYh:  return stat_addr + 16'd5;
      default: return stat_addr;
    endcase
  endfunction

endpackage

// File: rtl/ts_int_sync.sv
// Two-flop synchronizer for the panel interrupt line plus falling-edge detector.
module ts_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic ts_int_in,
  output logic int_fall
);

  logic sync1_q, sync2_q, prev_q;

  // Flops reset high (line idle) so leaving reset cannot look like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= ts_int_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign int_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/ts_poll_ctrl.sv
// Touch-panel poll controller: reads status/point registers over a byte-wide I2C
// command channel. Define TS_POLL_TIMER_EN to add a periodic poll timer trigger.
module ts_poll_ctrl
  import ts_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = DEF_POLL_CYCLES,
  parameter logic [15:0] STAT_ADDR   = DEF_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_done,
  input  logic        ts_int_in,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_we,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_err,
  output logic        pt_valid,
  output logic        pt_touch,
  output logic [11:0] pt_x,
  output logic [11:0] pt_y,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  ts_state_e   state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d, cmd_we_q, cmd_we_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_wdata_q, cmd_wdata_d;
  logic        wait_q, wait_d, pend_q, pend_d, abort_q, abort_d, touch_q, touch_d;
  logic [11:0] x_tmp_q, x_tmp_d, y_tmp_q, y_tmp_d;
  logic        pt_touch_q, pt_touch_d;
  logic [11:0] pt_x_q, pt_x_d, pt_y_q, pt_y_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        int_fall, tick, trig, rsp_fire, launch;

  ts_int_sync u_int_sync (
    .clk       (clk),
    .rst       (rst),
    .ts_int_in (ts_int_in),
    .int_fall  (int_fall)
  );

`ifdef TS_POLL_TIMER_EN
  logic [31:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    tick    = 1'b0;
    if (int_fall) begin
      timer_d = '0;
    end else if (rst_done) begin
      if (timer_q == 32'(POLL_CYCLES - 1)) begin
        timer_d = '0;
        tick    = 1'b1;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  logic unused_poll_cycles;
  assign unused_poll_cycles = ^POLL_CYCLES;
  assign tick = 1'b0;
`endif

  assign trig     = int_fall | tick;
  assign rsp_fire = wait_q & rsp_valid;

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    wait_d      = wait_q;
    pend_d      = pend_q;
    abort_d     = abort_q;
    touch_d     = touch_q;
    x_tmp_d     = x_tmp_q;
    y_tmp_d     = y_tmp_q;
    pt_touch_d  = pt_touch_q;
    pt_x_d      = pt_x_q;
    pt_y_d      = pt_y_q;
    err_cnt_d   = err_cnt_q;
    launch      = 1'b0;

    if (busy && trig) pend_d = 1'b1;
    // Panel reset mid-sequence: finish the bus transaction, then drop the data.
    if (busy && !rst_done) abort_d = 1'b1;
    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      wait_d      = 1'b1;
    end
    if (rsp_fire && rsp_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    case (state_q)
      StIdle: begin
        pend_d  = 1'b0;
        abort_d = 1'b0;
        if (rst_done && (trig || pend_q)) begin
          state_d = StRdStat;
          launch  = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        if (rsp_fire) begin
          wait_d = 1'b0;
          if (rsp_err || abort_q || !rst_done) begin
            state_d = StIdle;
          end else begin
            case (state_q)
              StRdStat: begin
                if (rsp_data[TOUCH_BIT]) begin
                  touch_d = |rsp_data[CNT_MSB:0];
                  state_d = touch_d ? StRdXl : StWrClr;
                  launch  = 1'b1;
                end else begin
                  state_d = StIdle;
                end
              end
              StRdXl: begin
                x_tmp_d[7:0] = rsp_data;
                state_d      = StRdXh;
                launch       = 1'b1;
              end
              StRdXh: begin
                x_tmp_d[11:8] = rsp_data[3:0];
                state_d       = StRdYl;
                launch        = 1'b1;
              end
              StRdYl: begin
                y_tmp_d[7:0] = rsp_data;
                state_d      = StRdYh;
                launch       = 1'b1;
              end
              StRdYh: begin
                y_tmp_d[11:8] = rsp_data[3:0];
                state_d       = StWrClr;
                launch        = 1'b1;
              end
              StWrClr: begin
                state_d    = StDone;
                pt_touch_d = touch_q;
                if (touch_q) begin
                  pt_x_d = x_tmp_q;
                  pt_y_d = y_tmp_q;
                end
              end
              default: state_d = StIdle;
            endcase
          end
        end
      end
    endcase

    if (launch) begin
      cmd_valid_d = 1'b1;
      cmd_we_d    = (state_d == StWrClr);
      cmd_addr_d  = reg_addr(STAT_ADDR, state_d);
      cmd_wdata_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      wait_q      <= 1'b0;
      pend_q      <= 1'b0;
      abort_q     <= 1'b0;
      touch_q     <= 1'b0;
      x_tmp_q     <= '0;
      y_tmp_q     <= '0;
      pt_touch_q  <= 1'b0;
      pt_x_q      <= '0;
      pt_y_q      <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      wait_q      <= wait_d;
      pend_q      <= pend_d;
      abort_q     <= abort_d;
      touch_q     <= touch_d;
      x_tmp_q     <= x_tmp_d;
      y_tmp_q     <= y_tmp_d;
      pt_touch_q  <= pt_touch_d;
      pt_x_q      <= pt_x_d;
      pt_y_q      <= pt_y_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign pt_valid  = (state_q == StDone);
  assign cmd_valid = cmd_valid_q;
  assign cmd_we    = cmd_we_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign pt_touch  = pt_touch_q;
  assign pt_x      = pt_x_q;
  assign pt_y      = pt_y_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/ts_poll_ctrl.md
TS_POLL_CTRL -- requirements
Module: ts_poll_ctrl

Interface
REQ-001 SHALL have parameter POLL_CYCLES, default 1000000, meaning the poll period in clk cycles (10 ms at 100 MHz).
REQ-002 SHALL have parameter STAT_ADDR, default 16'h814E, meaning the touch status register address; point registers are at STAT_ADDR+2..+5.
REQ-003 SHALL have the port clk  input  1  system clock.
REQ-004 SHALL have the port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have the port rst_done  input  1  touch panel hard-reset sequence complete (level).
REQ-006 SHALL have the port ts_int_in  input  1  asynchronous panel interrupt line, active-low event.
REQ-007 SHALL have the ports cmd_valid out 1, cmd_ready in 1, cmd_we out 1, cmd_addr out 16 and cmd_wdata out 8, forming the single-byte I2C master command channel.
REQ-008 SHALL have the ports rsp_valid in 1, rsp_data in 8 and rsp_err in 1, forming the I2C master response channel.
REQ-009 SHALL have the ports pt_valid out 1, pt_touch out 1, pt_x out 12 and pt_y out 12, carrying point results.
REQ-010 SHALL have the port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have the port err_cnt  output  8  count of rsp_err responses, saturating at 255.

Function
REQ-012 SHALL implement the states IDLE, RD_STAT, RD_XL, RD_XH, RD_YL, RD_YH, WR_CLR, DONE.
REQ-013 SHALL form a trigger from a falling edge of the synchronized ts_int_in, or from poll-timer expiry (see Configuration).
REQ-014 SHALL ignore triggers in IDLE while rst_done=0.
REQ-015 SHALL set one pending flag on any trigger while busy; multiple triggers coalesce into that one flag.
REQ-016 SHALL serve a pending trigger on the first IDLE cycle and clear the flag at that point.
REQ-017 SHALL move from IDLE to RD_STAT the cycle after a trigger or pending flag is seen with rst_done=1.
REQ-018 SHALL issue each state's single-byte command with cmd_valid=1.
REQ-019 SHALL hold cmd_we, cmd_addr and cmd_wdata stable until cmd_ready=1; cmd_valid SHALL drop the cycle after acceptance.
REQ-020 SHALL keep only one command outstanding and SHALL not issue the next command before rsp_valid for the current one.
REQ-021 SHALL ignore rsp_valid when no command is outstanding.
REQ-022 In RD_STAT, when status bit7=0, SHALL go to IDLE with no clear and no pt_valid.
REQ-023 In RD_STAT, when bit7=1 and bits[3:0]>=1, SHALL read XL, XH, YL and YH in order, then go to WR_CLR.
REQ-024 In RD_STAT, when bit7=1 and bits[3:0]=0, SHALL go directly to WR_CLR as a release event.
REQ-025 SHALL compute pt_x={XH[3:0],XL} and pt_y={YH[3:0],YL}.
REQ-026 WR_CLR SHALL write 8'h00 to STAT_ADDR.
REQ-027 After the WR_CLR response, DONE SHALL pulse pt_valid for exactly 1 cycle, then go to IDLE.
REQ-028 pt_touch SHALL be 1 for a touch event and 0 for a release event.
REQ-029 pt_x and pt_y SHALL update only for touch events and SHALL otherwise hold their values.
REQ-030 rsp_err=1 in any state SHALL increment err_cnt.
REQ-031 rsp_err=1 in a read state SHALL go to IDLE with no clear and no pt_valid.
REQ-032 rsp_err=1 in WR_CLR SHALL go to IDLE with no pt_valid.
REQ-033 If rst_done falls mid-sequence, the block SHALL complete the current handshake and response, then go to IDLE with data discarded and no pt_valid.

Reset
REQ-034 On rst=1 at a clk edge, the state SHALL become IDLE and cmd_valid, cmd_we, pt_valid, pt_touch and busy SHALL become 0.
REQ-035 On rst=1, cmd_addr, cmd_wdata, pt_x, pt_y and err_cnt SHALL become 0, and the pending flag, poll timer and synchronizer flops SHALL be cleared.
REQ-036 The synchronizer SHALL reset to 1 (line idle) so that release from reset creates no false edge.
REQ-037 Asserting rst mid-transaction SHALL abandon that transaction; a response arriving later SHALL be ignored per REQ-021.

Configuration
REQ-038 With TS_POLL_TIMER_EN defined, a 32-bit timer SHALL count while rst_done=1, and on reaching POLL_CYCLES-1 it SHALL wrap to 0 and raise a trigger.
REQ-039 With TS_POLL_TIMER_EN defined, the timer SHALL restart at 0 on every interrupt trigger.
REQ-040 Without TS_POLL_TIMER_EN, no timer logic SHALL exist and only interrupt edges SHALL trigger.

Structure
REQ-041 Package ts_pkg SHALL hold the state enum, the status-bit positions (TOUCH_BIT=7, CNT_MSB=3) and the default register address constants.
REQ-042 Sub-module ts_int_sync SHALL provide a 2-flop synchronizer plus falling-edge detect, with output int_fall as a 1-cycle pulse.

Verification
REQ-043 rst_done=1, ts_int_in 1->0, status 8'h81, XL/XH/YL/YH=8'h34/8'h02/8'h78/8'h01 -> 6 commands in order, last a write of 00 to 814E; pt_valid pulse with pt_x=12'h234, pt_y=12'h178, pt_touch=1.
REQ-044 Status 8'h80 -> RD_STAT then WR_CLR only; pt_valid with pt_touch=0; pt_x and pt_y unchanged.
REQ-045 Status 8'h00 -> one read only; no write, no pt_valid, busy low after the response.
REQ-046 rsp_err=1 on the RD_XH response -> err_cnt=1, no further commands, no pt_valid, state IDLE.
REQ-047 Three interrupt edges during a sequence -> exactly one extra sequence after DONE; with rst_done=0, an edge produces no command.
REQ-048 cmd_ready held low 5 cycles -> cmd fields stable throughout; with TS_POLL_TIMER_EN and POLL_CYCLES=100, the first RD_STAT is issued 100 cycles after rst_done rises with no interrupt.
